// File: rtl/clk_meter_pkg.sv
// rtl/clk_meter_pkg.sv - shared state type and defaults for the clock period meter
package clk_meter_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      MEAS
   } meter_state_t;

   localparam int CNT_W_DEF      = 24;
   localparam int LOCK_COUNT_DEF = 4;

   // Guard bits so measured-minus-expected never wraps.
   localparam int DIFF_GUARD_W   = 1;

endpackage

// File: rtl/clk_period_meter_sync_edge_detect.sv
// rtl/clk_period_meter_sync_edge_detect.sv - clk_in synchronizer with edge pulse
// edge_det flags a change at the synchronizer output; level is the synchronized value before that change.
module sync_edge_detect #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_hw,
   input  logic reset,
   input  logic clk_in,
   output logic edge_det,
   output logic level
);

   logic [SYNC_STAGES-1:0] sync;
   logic                   prev;

   always_ff @(posedge clk_hw or posedge reset) begin
      if (reset) begin
         sync <= '0;
         prev <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], clk_in};
         prev <= sync[SYNC_STAGES-1];
      end
   end

   assign edge_det = sync[SYNC_STAGES-1] ^ prev;
   assign level    = prev;

endmodule

// File: rtl/clk_period_meter.sv
// rtl/clk_period_meter.sv - measures clk_in half-periods in clk_hw cycles, reports lock and stall
// Optional duty-cycle check enabled by defining CLK_METER_DUTY_CHECK_EN.
module clk_period_meter
   import clk_meter_pkg::*;
#(
   parameter int          CNT_W          = CNT_W_DEF,
   parameter int          SYNC_STAGES    = 2,
   parameter int          LOCK_COUNT     = LOCK_COUNT_DEF,
   parameter int unsigned TIMEOUT_CYCLES = 24'hFFFFFF
) (
   input  logic             clk_hw,
   input  logic             reset,
   input  logic             enable,
   input  logic             clk_in,
   input  logic [CNT_W-1:0] expected_half,
   input  logic [7:0]       tolerance,
   output logic [CNT_W-1:0] half_period,
   output logic             period_valid,
   output logic             locked,
   output logic             timeout,
   output logic             duty_err
);

   localparam int               MC_W     = $clog2(LOCK_COUNT + 1);
   localparam int               DW       = CNT_W + DIFF_GUARD_W;
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [MC_W-1:0]  LOCK_MAX = MC_W'(LOCK_COUNT);

   function automatic logic [DW-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                              input logic [CNT_W-1:0] b);
      logic [DW-1:0] d;
      d = {{DIFF_GUARD_W{1'b0}}, a} - {{DIFF_GUARD_W{1'b0}}, b};
      return d[DW-1] ? (~d + DW'(1)) : d;
   endfunction

   meter_state_t     state, state_n;
   logic [CNT_W-1:0] count, count_n, count_sat, half_n;
   logic [MC_W-1:0]  mcnt, mcnt_n;
   logic             pv_n, locked_n, timeout_n, meas, to_hit, match;
   logic             edge_det;
   logic [DW-1:0]    tol_ext;

`ifdef CLK_METER_DUTY_CHECK_EN
   logic             level;
`else
   logic             level_unused;
`endif

   sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk_hw   (clk_hw),
      .reset    (reset),
      .clk_in   (clk_in),
      .edge_det (edge_det),
`ifdef CLK_METER_DUTY_CHECK_EN
      .level    (level)
`else
      .level    (level_unused)
`endif
   );

   // count+1 doubles as the new half-period, so both saturate together.
   assign count_sat = (count == '1) ? count : count + CNT_W'(1);
   assign tol_ext   = {{(DW-8){1'b0}}, tolerance};
   assign match     = abs_diff(count_sat, expected_half) <= tol_ext;

   always_comb begin
      state_n   = state;
      count_n   = count;
      half_n    = half_period;
      pv_n      = 1'b0;
      mcnt_n    = mcnt;
      locked_n  = locked;
      timeout_n = timeout;
      meas      = 1'b0;
      to_hit    = 1'b0;
      if (!enable) begin
         state_n   = IDLE;
         count_n   = '0;
         mcnt_n    = '0;
         locked_n  = 1'b0;
         timeout_n = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               count_n = '0;
               state_n = ARM;
            end
            ARM: begin
               if (edge_det) begin
                  count_n   = '0;
                  timeout_n = 1'b0;
                  state_n   = MEAS;
               end else if (count == TO_LAST) begin
                  to_hit = 1'b1;
               end else begin
                  count_n = count_sat;
               end
            end
            MEAS: begin
               if (edge_det) begin
                  meas      = 1'b1;
                  half_n    = count_sat;
                  pv_n      = 1'b1;
                  count_n   = '0;
                  timeout_n = 1'b0;
                  if (match) begin
                     if (mcnt != LOCK_MAX)
                        mcnt_n = mcnt + MC_W'(1);
                     locked_n = (mcnt_n == LOCK_MAX);
                  end else begin
                     mcnt_n   = '0;
                     locked_n = 1'b0;
                  end
               end else if (count == TO_LAST) begin
                  to_hit = 1'b1;
               end else begin
                  count_n = count_sat;
               end
            end
            default: state_n = IDLE;
         endcase
         if (to_hit) begin
            count_n   = '0;
            timeout_n = 1'b1;
            locked_n  = 1'b0;
            mcnt_n    = '0;
            state_n   = ARM;
         end
      end
   end

   always_ff @(posedge clk_hw or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         count        <= '0;
         mcnt         <= '0;
         half_period  <= '0;
         period_valid <= 1'b0;
         locked       <= 1'b0;
         timeout      <= 1'b0;
      end else begin
         state        <= state_n;
         count        <= count_n;
         mcnt         <= mcnt_n;
         half_period  <= half_n;
         period_valid <= pv_n;
         locked       <= locked_n;
         timeout      <= timeout_n;
      end
   end

`ifdef CLK_METER_DUTY_CHECK_EN
   logic [CNT_W-1:0] high_half, low_half, high_n, low_n;
   logic             have_high, have_low, have_high_n, have_low_n, duty_n;

   // level is the synchronized clk_in before the edge, i.e. the half just completed.
   always_comb begin
      high_n      = high_half;
      low_n       = low_half;
      have_high_n = have_high;
      have_low_n  = have_low;
      duty_n      = duty_err;
      if (!enable || state == IDLE || to_hit) begin
         have_high_n = 1'b0;
         have_low_n  = 1'b0;
         duty_n      = 1'b0;
      end else if (meas) begin
         if (level) begin
            high_n      = count_sat;
            have_high_n = 1'b1;
         end else begin
            low_n       = count_sat;
            have_low_n  = 1'b1;
         end
         if (have_high_n && have_low_n)
            duty_n = abs_diff(high_n, low_n) > tol_ext;
      end
   end

   always_ff @(posedge clk_hw or posedge reset) begin
      if (reset) begin
         high_half <= '0;
         low_half  <= '0;
         have_high <= 1'b0;
         have_low  <= 1'b0;
         duty_err  <= 1'b0;
      end else begin
         high_half <= high_n;
         low_half  <= low_n;
         have_high <= have_high_n;
         have_low  <= have_low_n;
         duty_err  <= duty_n;
      end
   end
`else
   assign duty_err = 1'b0;
`endif

endmodule

// File: tb/tb_clk_period_meter.sv
// tb/tb_clk_period_meter.sv - directed self-checking bench for clk_period_meter
module tb_clk_period_meter;

   logic        clk_hw = 1'b0;
   logic        reset;
   logic        enable;
   logic        clk_in = 1'b0;
   logic [23:0] expected_half;
   logic [7:0]  tolerance;
   logic [23:0] half_period;
   logic        period_valid;
   logic        locked;
   logic        timeout;
   logic        duty_err;

   int n_checks = 0;
   int n_pass   = 0;
   bit gen_run  = 1'b0;
   int hi_len   = 5;
   int lo_len   = 5;
   int gen_cnt  = 0;
   int toggles  = 0;
   int cyc      = 0;

   always #5 clk_hw = ~clk_hw;

   clk_period_meter #(
      .CNT_W          (24),
      .SYNC_STAGES    (2),
      .LOCK_COUNT     (4),
      .TIMEOUT_CYCLES (64)
   ) dut (
      .clk_hw        (clk_hw),
      .reset         (reset),
      .enable        (enable),
      .clk_in        (clk_in),
      .expected_half (expected_half),
      .tolerance     (tolerance),
      .half_period   (half_period),
      .period_valid  (period_valid),
      .locked        (locked),
      .timeout       (timeout),
      .duty_err      (duty_err)
   );

   always @(posedge clk_hw) cyc <= cyc + 1;

   // clk_in transitions land 1 time unit after a clk_hw edge, len cycles apart.
   always begin
      @(posedge clk_hw);
      #1;
      if (gen_run) begin
         gen_cnt++;
         if (gen_cnt >= (clk_in ? hi_len : lo_len)) begin
            clk_in  = ~clk_in;
            gen_cnt = 0;
            toggles++;
         end
      end
   end

   task automatic wait_pv(input string name);
      bit seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge clk_hw);
         seen = period_valid;
      end
      n_checks++;
      if (seen) n_pass++;
      else $display("FAIL %s: period_valid=0 after 300 cycles, required 1", name);
   endtask

   task automatic test_reset;
      reset = 1'b1; enable = 1'b0; expected_half = 24'd5; tolerance = 8'd0;
      repeat (3) @(negedge clk_hw);
      n_checks++; if (half_period !== 24'd0) $display("FAIL rst_half: got %0d required 0", half_period); else n_pass++;
      n_checks++; if (period_valid !== 1'b0) $display("FAIL rst_pv: got %0b required 0", period_valid); else n_pass++;
      n_checks++; if (locked !== 1'b0) $display("FAIL rst_locked: got %0b required 0", locked); else n_pass++;
      n_checks++; if (timeout !== 1'b0) $display("FAIL rst_timeout: got %0b required 0", timeout); else n_pass++;
      n_checks++; if (duty_err !== 1'b0) $display("FAIL rst_duty: got %0b required 0", duty_err); else n_pass++;
      reset = 1'b0;
   endtask

   task automatic test_lock;
      int last = 0;
      enable = 1'b1; hi_len = 5; lo_len = 5; gen_run = 1'b1;
      for (int m = 1; m <= 4; m++) begin
         wait_pv("lock_wait");
         if (m == 1) begin
            n_checks++; if (toggles !== 2) $display("FAIL lock_first_edge: toggles=%0d required 2", toggles); else n_pass++;
         end else begin
            n_checks++; if (cyc - last !== 5) $display("FAIL lock_gap: got %0d required 5", cyc - last); else n_pass++;
         end
         last = cyc;
         n_checks++; if (half_period !== 24'd5) $display("FAIL lock_half: got %0d required 5", half_period); else n_pass++;
         n_checks++; if (locked !== (m == 4)) $display("FAIL lock_state m=%0d: got %0b required %0b", m, locked, m == 4); else n_pass++;
      end
   endtask

   task automatic test_mismatch;
      hi_len = 8; lo_len = 8; tolerance = 8'd1;
      wait_pv("mis_wait1");
      n_checks++; if (half_period !== 24'd8) $display("FAIL mis_half: got %0d required 8", half_period); else n_pass++;
      n_checks++; if (locked !== 1'b0) $display("FAIL mis_drop: got %0b required 0", locked); else n_pass++;
      wait_pv("mis_wait2");
      n_checks++; if (locked !== 1'b0) $display("FAIL mis_stay: got %0b required 0", locked); else n_pass++;
      expected_half = 24'd8;
      for (int m = 1; m <= 4; m++) begin
         wait_pv("relock_wait");
         if (m >= 3) begin
            n_checks++; if (locked !== (m == 4)) $display("FAIL relock m=%0d: got %0b required %0b", m, locked, m == 4); else n_pass++;
         end
      end
   endtask

   task automatic test_timeout;
      bit early = 1'b0, cleared = 1'b0, pv_seen = 1'b0;
      gen_run = 1'b0;
      for (int k = 1; k < 64; k++) begin
         @(negedge clk_hw);
         if (timeout) early = 1'b1;
      end
      n_checks++; if (early !== 1'b0) $display("FAIL to_early: got %0b required 0", early); else n_pass++;
      @(negedge clk_hw);
      n_checks++; if (timeout !== 1'b1) $display("FAIL to_at64: got %0b required 1", timeout); else n_pass++;
      n_checks++; if (locked !== 1'b0) $display("FAIL to_locked: got %0b required 0", locked); else n_pass++;
      n_checks++; if (half_period !== 24'd8) $display("FAIL to_half_hold: got %0d required 8", half_period); else n_pass++;
      gen_run = 1'b1;
      for (int k = 0; k < 40 && !cleared; k++) begin
         @(negedge clk_hw);
         if (period_valid) pv_seen = 1'b1;
         cleared = !timeout;
      end
      n_checks++; if (cleared !== 1'b1) $display("FAIL to_clear: got %0b required 1", cleared); else n_pass++;
      n_checks++; if (pv_seen !== 1'b0) $display("FAIL to_arm_pv: got %0b required 0", pv_seen); else n_pass++;
      for (int m = 1; m <= 4; m++) wait_pv("to_relock_wait");
      n_checks++; if (locked !== 1'b1) $display("FAIL to_relock: got %0b required 1", locked); else n_pass++;
   endtask

   task automatic test_reset_mid;
      bit low_pv = 1'b0;
      int t0;
      for (int t = 0; t < 4 && !low_pv; t++) begin
         wait_pv("rmid_wait");
         low_pv = (clk_in == 1'b0);
      end
      repeat (3) @(negedge clk_hw);
      reset = 1'b1;
      #1;
      n_checks++; if (half_period !== 24'd0) $display("FAIL rmid_half: got %0d required 0", half_period); else n_pass++;
      n_checks++; if (period_valid !== 1'b0) $display("FAIL rmid_pv: got %0b required 0", period_valid); else n_pass++;
      n_checks++; if (locked !== 1'b0) $display("FAIL rmid_locked: got %0b required 0", locked); else n_pass++;
      @(negedge clk_hw);
      reset = 1'b0;
      t0 = toggles;
      wait_pv("rmid_pv");
      n_checks++; if (toggles - t0 !== 2) $display("FAIL rmid_first_edge: toggles=%0d required 2", toggles - t0); else n_pass++;
      n_checks++; if (half_period !== 24'd8) $display("FAIL rmid_half2: got %0d required 8", half_period); else n_pass++;
   endtask

   task automatic test_enable;
      for (int m = 1; m <= 3; m++) wait_pv("en_lock_wait");
      n_checks++; if (locked !== 1'b1) $display("FAIL en_locked: got %0b required 1", locked); else n_pass++;
      enable = 1'b0;
      repeat (2) @(negedge clk_hw);
      n_checks++; if (locked !== 1'b0) $display("FAIL en_clear_lock: got %0b required 0", locked); else n_pass++;
      enable = 1'b1;
      for (int m = 1; m <= 4; m++) begin
         wait_pv("en_relock_wait");
         if (m >= 3) begin
            n_checks++; if (locked !== (m == 4)) $display("FAIL en_relock m=%0d: got %0b required %0b", m, locked, m == 4); else n_pass++;
         end
      end
      gen_run = 1'b0;
      repeat (70) @(negedge clk_hw);
      n_checks++; if (timeout !== 1'b1) $display("FAIL en_to_set: got %0b required 1", timeout); else n_pass++;
      enable = 1'b0;
      repeat (2) @(negedge clk_hw);
      n_checks++; if (timeout !== 1'b0) $display("FAIL en_clear_to: got %0b required 0", timeout); else n_pass++;
      enable = 1'b1;
   endtask

   task automatic test_boundary;
      bit to_seen = 1'b0;
      expected_half = 24'd64; tolerance = 8'd0; hi_len = 64; lo_len = 64; gen_run = 1'b1;
      wait_pv("bnd_wait1");
      for (int m = 0; m < 2; m++) begin
         bit seen = 1'b0;
         for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk_hw);
            if (timeout) to_seen = 1'b1;
            seen = period_valid;
         end
         n_checks++; if (seen !== 1'b1) $display("FAIL bnd_pv: got %0b required 1", seen); else n_pass++;
         n_checks++; if (half_period !== 24'd64) $display("FAIL bnd_half: got %0d required 64", half_period); else n_pass++;
      end
      n_checks++; if (to_seen !== 1'b0) $display("FAIL bnd_edge_wins: timeout=%0b required 0", to_seen); else n_pass++;
   endtask

   task automatic test_duty;
      logic [23:0] h1;
      bit exp_duty;
`ifdef CLK_METER_DUTY_CHECK_EN
      exp_duty = 1'b1;
`else
      exp_duty = 1'b0;
`endif
      hi_len = 3; lo_len = 7; tolerance = 8'd2; expected_half = 24'd5;
      enable = 1'b0;
      repeat (2) @(negedge clk_hw);
      enable = 1'b1;
      wait_pv("duty_wait1");
      h1 = half_period;
      n_checks++; if (duty_err !== 1'b0) $display("FAIL duty_first: got %0b required 0", duty_err); else n_pass++;
      wait_pv("duty_wait2");
      n_checks++; if (h1 + half_period !== 24'd10) $display("FAIL duty_pair: got %0d required 10", h1 + half_period); else n_pass++;
      n_checks++; if (duty_err !== exp_duty) $display("FAIL duty_3_7: got %0b required %0b", duty_err, exp_duty); else n_pass++;
      hi_len = 5; lo_len = 5;
      for (int m = 0; m < 3; m++) wait_pv("duty_wait3");
      n_checks++; if (duty_err !== 1'b0) $display("FAIL duty_5_5: got %0b required 0", duty_err); else n_pass++;
   endtask

   initial begin
      test_reset;
      test_lock;
      test_mismatch;
      test_timeout;
      test_reset_mid;
      test_enable;
      test_boundary;
      test_duty;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
      $fatal(1);
   end

endmodule
